// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) encode stage: FSM states, code
// geometry and the codeword position of every parity and data bit.
package hamming_pkg;

  localparam int DATA_BITS    = 4;
  localparam int HAMMING_BITS = 7;

  // Hamming positions are 1-based; codeword bit (k-1) holds position k.
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D1 = 3;
  localparam int POS_P4 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_D4 = 7;

  typedef enum logic [2:0] {
    GET_REQ = 3'd0,
    GET_REL = 3'd1,
    ENCODE  = 3'd2,
    PUT_REQ = 3'd3,
    PUT_REL = 3'd4
  } state_e;

  // One-hot flip mask for a Hamming position; position 0 selects nothing.
  function automatic logic [HAMMING_BITS-1:0] pos_mask(input logic [2:0] pos);
    logic [HAMMING_BITS-1:0] mask;
    mask = '0;
    for (int k = 0; k < HAMMING_BITS; k++) begin
      mask[k] = (pos == 3'(k + 1));
    end
    return mask;
  endfunction

endpackage

// File: rtl/hamming74_encode.sv
// Combinational Hamming(7,4) encoder: 4 data bits to a 7-bit codeword,
// position k of the code in bit k-1.
module hamming74_encode
  import hamming_pkg::*;
(
  input  logic [DATA_BITS-1:0]    data_i,
  output logic [HAMMING_BITS-1:0] code_o
);

  logic d1, d2, d3, d4;

  always_comb begin
    d1 = data_i[0];
    d2 = data_i[1];
    d3 = data_i[2];
    d4 = data_i[3];

    code_o             = '0;
    code_o[POS_P1 - 1] = d1 ^ d2 ^ d4;
    code_o[POS_P2 - 1] = d1 ^ d3 ^ d4;
    code_o[POS_D1 - 1] = d1;
    code_o[POS_P4 - 1] = d2 ^ d3 ^ d4;
    code_o[POS_D2 - 1] = d2;
    code_o[POS_D3 - 1] = d3;
    code_o[POS_D4 - 1] = d4;
  end

endmodule

// File: rtl/hamming_encode_stage.sv
// FIFO-to-FIFO stage: pulls 4-bit words over a four-phase get handshake,
// Hamming-encodes them (optionally SEC-DED) and pushes them four-phase.
module hamming_encode_stage
  import hamming_pkg::*;
#(
  parameter  int EXTENDED   = 0,
  parameter  int COUNT_BITS = 16,
  localparam int CODE_BITS  = HAMMING_BITS + EXTENDED
) (
  input  logic                  clock,
  input  logic                  clear_n,
  output logic                  get_req,
  input  logic                  get_ack,
  input  logic [DATA_BITS-1:0]  get_value,
  output logic                  put_req,
  input  logic                  put_ack,
  output logic [CODE_BITS-1:0]  put_value,
  input  logic                  inject_en,
  input  logic [2:0]            inject_pos,
  output logic [COUNT_BITS-1:0] words_encoded,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic                    get_req_q, get_req_d;
  logic                    put_req_q, put_req_d;
  logic                    busy_q, busy_d;
  logic [DATA_BITS-1:0]    data_q, data_d;
  logic [CODE_BITS-1:0]    put_value_q, put_value_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;

  logic [HAMMING_BITS-1:0] ham_code;
  logic [HAMMING_BITS-1:0] inject_mask;
  logic [CODE_BITS-1:0]    code_full;

  hamming74_encode u_enc (
    .data_i (data_q),
    .code_o (ham_code)
  );

  assign inject_mask = inject_en ? pos_mask(inject_pos) : '0;

  // Overall parity covers the clean code, so an injected flip reads as a
  // single-bit error downstream; bit 7 itself is never flipped.
  if (EXTENDED != 0) begin : g_ext
    assign code_full = {^ham_code, ham_code ^ inject_mask};
  end else begin : g_plain
    assign code_full = ham_code ^ inject_mask;
  end

  always_comb begin
    state_d     = state_q;
    get_req_d   = get_req_q;
    put_req_d   = put_req_q;
    busy_d      = busy_q;
    data_d      = data_q;
    put_value_d = put_value_q;
    count_d     = count_q;

    unique case (state_q)
      GET_REQ: begin
        // After reset the request is low; raise it once the ack is seen low.
        if (!get_req_q) begin
          if (!get_ack) get_req_d = 1'b1;
        end else if (get_ack) begin
          data_d    = get_value;
          get_req_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = GET_REL;
        end
      end
      GET_REL: begin
        if (!get_ack) state_d = ENCODE;
      end
      ENCODE: begin
        put_value_d = code_full;
        put_req_d   = 1'b1;
        state_d     = PUT_REQ;
      end
      PUT_REQ: begin
        if (put_ack) begin
          put_req_d = 1'b0;
          count_d   = count_q + COUNT_BITS'(1);
          busy_d    = 1'b0;
          state_d   = PUT_REL;
        end
      end
      PUT_REL: begin
        if (!put_ack) begin
          get_req_d = 1'b1;
          state_d   = GET_REQ;
        end
      end
      default: state_d = GET_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q     <= GET_REQ;
      get_req_q   <= 1'b0;
      put_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      put_value_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      get_req_q   <= get_req_d;
      put_req_q   <= put_req_d;
      busy_q      <= busy_d;
      put_value_q <= put_value_d;
      count_q     <= count_d;
    end
  end

  // The held data word needs no reset: it is only read after a fresh capture.
  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  assign get_req       = get_req_q;
  assign put_req       = put_req_q;
  assign put_value     = put_value_q;
  assign words_encoded = count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_hamming_encode_stage.sv
// Drives a plain (7,4) instance and a SEC-DED instance with a 4-bit counter
// in lockstep from shared FIFO-side handshakes and checks both.
module tb_hamming_encode_stage;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        get_ack = 1'b0;
  logic        put_ack = 1'b0;
  logic [3:0]  get_value = 4'h0;
  logic        inject_en = 1'b0;
  logic [2:0]  inject_pos = 3'd0;

  logic        get_req0, put_req0, busy0;
  logic [6:0]  pv0;
  logic [15:0] we0;
  logic        get_req1, put_req1, busy1;
  logic [7:0]  pv1;
  logic [3:0]  we1;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cnt = 0;

  always #5 clock = ~clock;

  hamming_encode_stage #(.EXTENDED(0), .COUNT_BITS(16)) dut0 (
    .clock(clock), .clear_n(clear_n),
    .get_req(get_req0), .get_ack(get_ack), .get_value(get_value),
    .put_req(put_req0), .put_ack(put_ack), .put_value(pv0),
    .inject_en(inject_en), .inject_pos(inject_pos),
    .words_encoded(we0), .busy(busy0)
  );

  hamming_encode_stage #(.EXTENDED(1), .COUNT_BITS(4)) dut1 (
    .clock(clock), .clear_n(clear_n),
    .get_req(get_req1), .get_ack(get_ack), .get_value(get_value),
    .put_req(put_req1), .put_ack(put_ack), .put_value(pv1),
    .inject_en(inject_en), .inject_pos(inject_pos),
    .words_encoded(we1), .busy(busy1)
  );

  typedef struct {
    logic [3:0] d;
    logic       ien;
    logic [2:0] ipos;
    logic [7:0] exp;
  } vec_t;

  vec_t       vt[12];
  logic [7:0] code8[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Request rises only when the matching ack was low at that edge.
  logic pg0 = 1'b0, pg1 = 1'b0, pp0 = 1'b0, pp1 = 1'b0, pga = 1'b0, ppa = 1'b0;
  always @(negedge clock) begin
    if (get_req0 && !pg0) chk("get_req0_rise_ack_low", pga, 0);
    if (get_req1 && !pg1) chk("get_req1_rise_ack_low", pga, 0);
    if (put_req0 && !pp0) chk("put_req0_rise_ack_low", ppa, 0);
    if (put_req1 && !pp1) chk("put_req1_rise_ack_low", ppa, 0);
    pg0 = get_req0; pg1 = get_req1; pp0 = put_req0; pp1 = put_req1;
    pga = get_ack;  ppa = put_ack;
  end

  task automatic chk_count();
    chk("words_encoded16", we0, cnt % 65536);
    chk("words_encoded4", we1, cnt % 16);
  endtask

  task automatic do_reset();
    clear_n = 1'b0; get_ack = 1'b0; put_ack = 1'b0;
    tick(); tick();
    chk("rst_get_req", {get_req0, get_req1}, 0);
    chk("rst_put_req", {put_req0, put_req1}, 0);
    chk("rst_put_value", {pv0, pv1}, 0);
    chk("rst_busy", {busy0, busy1}, 0);
    cnt = 0;
    chk_count();
    clear_n = 1'b1;
    tick();
    chk("rel_get_req", {get_req0, get_req1}, 2'b11);
  endtask

  task automatic wait_get_req();
    for (int i = 0; i < 50 && !(get_req0 && get_req1); i++) tick();
    chk("wait_get_req", {get_req0, get_req1}, 2'b11);
  endtask

  task automatic do_word(input logic [3:0] d, input logic ien, input logic [2:0] ipos,
                         input logic [7:0] exp, input int get_hold, input int stall,
                         input int put_hold);
    wait_get_req();
    get_value = d; get_ack = 1'b1; inject_en = ien; inject_pos = ipos;
    tick();
    chk("cap_get_req", {get_req0, get_req1}, 0);
    chk("cap_busy", {busy0, busy1}, 2'b11);
    for (int k = 1; k < get_hold; k++) begin
      tick();
      chk("ackhi_reqs", {get_req0, get_req1, put_req0, put_req1}, 0);
    end
    get_ack = 1'b0; get_value = ~d;
    tick();
    chk("encode_put_req", {put_req0, put_req1}, 0);
    tick();
    chk("latency_put_req", {put_req0, put_req1}, 2'b11);
    chk("put_value7", pv0, exp[6:0]);
    chk("put_value8", pv1, exp);
    inject_en = 1'b0; inject_pos = 3'd0;
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("stall_put_req", {put_req0, put_req1}, 2'b11);
      chk("stall_value", {pv0, pv1}, {exp[6:0], exp});
      chk("stall_get_req", {get_req0, get_req1}, 0);
      chk("stall_busy", {busy0, busy1}, 2'b11);
    end
    put_ack = 1'b1;
    tick();
    cnt++;
    chk("ack_put_req", {put_req0, put_req1}, 0);
    chk("ack_busy", {busy0, busy1}, 0);
    chk_count();
    for (int k = 1; k < put_hold; k++) begin
      tick();
      chk("putack_hi_get_req", {get_req0, get_req1}, 0);
    end
    put_ack = 1'b0;
    tick();
    chk("next_get_req", {get_req0, get_req1}, 2'b11);
  endtask

  initial begin
    code8 = '{8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
              8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF};
    vt[0]  = '{4'b1011, 1'b0, 3'd0, 8'h55};
    vt[1]  = '{4'b0000, 1'b0, 3'd0, 8'h00};
    vt[2]  = '{4'b0001, 1'b0, 3'd0, 8'h87};
    vt[3]  = '{4'b1111, 1'b0, 3'd0, 8'hFF};
    vt[4]  = '{4'b1011, 1'b1, 3'd3, 8'h51};
    vt[5]  = '{4'b1011, 1'b1, 3'd0, 8'h55};
    vt[6]  = '{4'b1011, 1'b0, 3'd5, 8'h55};
    vt[7]  = '{4'b1011, 1'b1, 3'd7, 8'h15};
    vt[8]  = '{4'b0001, 1'b1, 3'd1, 8'h86};
    vt[9]  = '{4'b0010, 1'b0, 3'd0, 8'h99};
    vt[10] = '{4'b0100, 1'b0, 3'd0, 8'hAA};
    vt[11] = '{4'b1000, 1'b0, 3'd0, 8'h4B};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_word(vt[i].d, vt[i].ien, vt[i].ipos, vt[i].exp, 1, 0, 1);
    end

    // Downstream full for 20 cycles, long get and put acks.
    do_word(4'b1011, 1'b0, 3'd0, 8'h55, 3, 20, 3);

    // Reset while a word waits in PUT_REQ: it must be dropped.
    wait_get_req();
    get_value = 4'b0110; get_ack = 1'b1;
    tick();
    get_ack = 1'b0;
    tick(); tick();
    chk("pre_clear_put_req", {put_req0, put_req1}, 2'b11);
    clear_n = 1'b0;
    tick();
    cnt = 0;
    chk("mid_clear_put_req", {put_req0, put_req1}, 0);
    chk("mid_clear_get_req", {get_req0, get_req1}, 0);
    chk("mid_clear_value", {pv0, pv1}, 0);
    chk("mid_clear_busy", {busy0, busy1}, 0);
    chk_count();
    clear_n = 1'b1;
    tick();
    chk("post_clear_get_req", {get_req0, get_req1}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_stale_put_req", {put_req0, put_req1}, 0);
    end
    do_word(4'b0011, 1'b0, 3'd0, 8'h1E, 1, 0, 1);

    // 17-word stream wraps the 4-bit counter to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      do_word(4'(i), 1'b0, 3'd0, code8[i % 16], (i % 3) + 1, i % 2, (i % 2) + 1);
    end
    chk("wrap_count4", we1, 1);
    chk("wrap_count16", we0, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_encode_stage.md
Name: hamming_encode_stage

Overview:
- Downstream consumer of the upstream push/pull FIFO's get port.
- Pulls 4-bit data words with a four-phase get_req/get_ack handshake and encodes each as Hamming(7,4), optionally extended with an overall parity bit for SEC-DED.
- Pushes each codeword into the next FIFO's put port with a four-phase put_req/put_ack handshake.
- Optional single-bit error injection, for exercising the downstream decoder.

Parameters:
- EXTENDED, 0: 1 appends the overall parity bit, giving CODE_BITS = 7 + EXTENDED.
- COUNT_BITS, 16: width of the words_encoded counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- get_req  out  1  request to the upstream FIFO get port.
- get_ack  in  1  upstream acknowledge; get_value is valid in the cycle get_ack is high.
- get_value  in  4  data word from upstream.
- put_req  out  1  request to the downstream FIFO put port.
- put_ack  in  1  downstream acknowledge.
- put_value  out  CODE_BITS  codeword to downstream.
- inject_en  in  1  enables error injection on the next encoded word.
- inject_pos  in  3  Hamming position 1..7 to flip; 0 means no flip.
- words_encoded  out  COUNT_BITS  count of codewords accepted downstream; wraps modulo 2^COUNT_BITS.
- busy  out  1  high while a word is held in the stage, from the get_ack capture until the put_ack is seen.

Behaviour:
- Reset: while clear_n = 0 at an edge:
  - get_req = 0, put_req = 0, put_value = 0, words_encoded = 0, busy = 0.
  - State returns to GET_REQ.
  - This applies mid-handshake too: any held word is discarded. Both neighbouring FIFOs are cleared in the same cycle by the system.
- Handshake rule, both ports: a req rises only while its ack is low. Once the req is high, it stays high until the ack is sampled high, then drops on that edge. The FSM then waits for the ack to be sampled low before that port may request again. Ack may be a single-cycle pulse.
- State GET_REQ: get_req = 1. On an edge with get_ack = 1:
  - data_reg <= get_value.
  - get_req <= 0, busy <= 1.
  - Go to GET_REL.
- State GET_REL: get_req = 0. On an edge with get_ack = 0, go to ENCODE.
- State ENCODE: one cycle. At the edge:
  - put_value <= encode(data_reg) ^ inject_mask.
  - put_req <= 1.
  - Go to PUT_REQ.
- State PUT_REQ: put_req = 1. put_value is held stable.
  - On an edge with put_ack = 1: put_req <= 0, words_encoded <= words_encoded + 1, busy <= 0, go to PUT_REL.
- State PUT_REL: on an edge with put_ack = 0, go to GET_REQ (get_req <= 1).
- Data-bit mapping: d1 = data[0], d2 = data[1], d3 = data[2], d4 = data[3].
- Parity bits:
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p4 = d2^d3^d4
- Codeword layout: bit (k-1) holds Hamming position k, with positions 1..7 = p1 p2 d1 p4 d2 d3 d4.
- EXTENDED = 1: bit 7 = XOR of bits 6..0, computed before injection. An injected error therefore shows up as a single-bit error to the decoder.
- inject_mask: zero unless inject_en = 1 and inject_pos != 0, in which case it is 1 << (inject_pos - 1). inject_en and inject_pos are sampled only in ENCODE. Bit 7 is never injected.
- Minimum latency: get_ack sampled high to put_req high is 2 cycles when get_ack is a one-cycle pulse (GET_REL, ENCODE); it stretches while get_ack stays high.
- Counter wrap: words_encoded goes from all-ones to 0 silently.
- Stalls:
  - Upstream empty: the FIFO never acks, so the stage sits in GET_REQ indefinitely.
  - Downstream full: the stage sits in PUT_REQ with put_value held.
  - No timeout in either case.

Decomposition:
- Package hamming_pkg holds:
  - state enum: GET_REQ, GET_REL, ENCODE, PUT_REQ, PUT_REL.
  - DATA_BITS = 4, HAMMING_BITS = 7.
  - Position constants for p1/p2/p4/d1..d4.
- Sub-module hamming74_encode (combinational: 4-bit data to 7-bit codeword). It is reused later by the decoder bench model.
- Extended parity and injection are done in this block.

Test Plan:
- Reset, then upstream FIFO holding 4'b1011 with EXTENDED=0 -> put_value = 7'h55, put_req high 2 cycles after get_ack; after put_ack, words_encoded = 1.
- EXTENDED=1, feed 4'b0000, 4'b0001, 4'b1111 -> put_value 8'h00, 8'h87, 8'hFF in order; words_encoded = 3.
- EXTENDED=1, inject_en=1, inject_pos=3, data 4'b1011 -> put_value = 8'h51 (bit 7 stays 0); inject_pos=0 -> 8'h55.
- Downstream FIFO full (put_ack withheld 20 cycles) -> put_req stays high and put_value constant; get_req stays low; busy = 1; after put_ack, the next get_req rises only after put_ack is low.
- Assert clear_n = 0 for one cycle while in PUT_REQ -> next edge: put_req = 0, get_req = 0, words_encoded = 0; after release, get_req = 1 and no stale word is emitted.
- COUNT_BITS=4, stream 17 words -> words_encoded reads 1; the handshake never raises a req while its ack is high (assertion checked every cycle).
